// File: rtl/hazard_bypass_if.sv
// Decode-side bundle between the decode stage and the hazard/bypass unit:
// instruction descriptor and flush in, stall and bypass selects out.
interface hazard_bypass_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic                      id_uses_rs;
  logic                      id_uses_rt;
  logic                      id_is_store;
  logic                      id_is_load;
  logic                      id_write_to_reg;
  logic [REG_ADDR_WIDTH-1:0] id_dest;
  logic                      flush;
  logic                      stall;
  logic                      mx_op1_bypass;
  logic                      mx_op2_bypass;
  logic                      wx_op1_bypass;
  logic                      wx_op2_bypass;
  logic                      wm_data_bypass;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_store,
           id_is_load, id_write_to_reg, id_dest, flush,
    input  stall, mx_op1_bypass, mx_op2_bypass, wx_op1_bypass,
           wx_op2_bypass, wm_data_bypass
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_store,
           id_is_load, id_write_to_reg, id_dest, flush,
    output stall, mx_op1_bypass, mx_op2_bypass, wx_op1_bypass,
           wx_op2_bypass, wm_data_bypass
  );
endinterface

// File: rtl/hazard_bypass_unit.sv
// Decode-stage hazard detector and bypass-select generator with a shadow
// scoreboard of in-flight destinations and a saturating load-use stall counter.
module hazard_bypass_unit #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_bypass_if.slave       bus,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef struct packed {
    logic                      v;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic                      ld;
  } sb_entry_t;

  // WB never matches (register file writes before it reads), so only IX and MEM are tracked.
  sb_entry_t ix_q, ix_d;
  sb_entry_t mem_q, mem_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic rs_ix, rs_mem, rt_ix, rt_mem;
  logic stall, issue;
  logic mx_op1, mx_op2, wx_op1, wx_op2, wm_data;

  always_comb begin
    rs_ix  = ix_q.v  && (ix_q.dest  == bus.id_rs) && (bus.id_rs != '0);
    rs_mem = mem_q.v && (mem_q.dest == bus.id_rs) && (bus.id_rs != '0);
    rt_ix  = ix_q.v  && (ix_q.dest  == bus.id_rt) && (bus.id_rt != '0);
    rt_mem = mem_q.v && (mem_q.dest == bus.id_rt) && (bus.id_rt != '0);

    // Store data behind a load is forwarded WB->MEM instead of stalling.
    stall = bus.id_valid && !bus.flush && ix_q.ld &&
            ((bus.id_uses_rs && rs_ix) ||
             (bus.id_uses_rt && !bus.id_is_store && rt_ix));
    issue = bus.id_valid && !bus.flush && !stall;

    mx_op1  = issue && bus.id_uses_rs && rs_ix && !ix_q.ld;
    wx_op1  = issue && bus.id_uses_rs && rs_mem && !rs_ix;
    mx_op2  = issue && bus.id_uses_rt && rt_ix && !ix_q.ld;
    wx_op2  = issue && bus.id_uses_rt && rt_mem && !rt_ix;
    wm_data = issue && bus.id_is_store && bus.id_uses_rt && rt_ix && ix_q.ld;

    mem_d = ix_q;
    ix_d  = '0;
    if (issue) begin
      ix_d.v    = bus.id_write_to_reg && (bus.id_dest != '0);
      ix_d.dest = bus.id_dest;
      ix_d.ld   = bus.id_is_load;
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      ix_q          <= '0;
      mem_q         <= '0;
      stall_count_q <= '0;
    end else begin
      ix_q          <= ix_d;
      mem_q         <= mem_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall          = stall;
  assign bus.mx_op1_bypass  = mx_op1;
  assign bus.mx_op2_bypass  = mx_op2;
  assign bus.wx_op1_bypass  = wx_op1;
  assign bus.wx_op2_bypass  = wx_op2;
  assign bus.wm_data_bypass = wm_data;
  assign stall_count        = stall_count_q;

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Bench for hazard_bypass_unit: directed instruction sequences, a per-cycle
// comparison against an issue-history model, and hand-computed spot checks.
module tb_hazard_bypass_unit;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;
  localparam int          CNT_MAX = 15;

  logic clk = 1'b1;
  logic rst = 1'b1;
  logic [CW-1:0] stall_count;

  hazard_bypass_if #(.REG_ADDR_WIDTH(RW)) bus ();

  hazard_bypass_unit #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of the two most recently issued instructions (age 0 = IX, age 1 = MEM).
  typedef struct {
    bit writes;
    int dest;
    bit load;
  } issued_t;

  issued_t hist[2];
  int      m_cnt    = 0;
  bit      model_ok = 0;

  function automatic bit produces(input issued_t p, input int r);
    return p.writes && (p.dest == r) && (r != 0);
  endfunction

  function automatic bit m_stall();
    bit rs_dep, rt_dep;
    rs_dep = bus.id_uses_rs && produces(hist[0], int'(bus.id_rs));
    rt_dep = bus.id_uses_rt && !bus.id_is_store && produces(hist[0], int'(bus.id_rt));
    return bus.id_valid && !bus.flush && hist[0].load && (rs_dep || rt_dep);
  endfunction

  // {stall, mx1, mx2, wx1, wx2, wm}
  function automatic logic [5:0] m_outs();
    bit go, s;
    bit a_ix, a_mem, b_ix, b_mem;
    logic [5:0] o;
    s     = m_stall();
    go    = bus.id_valid && !bus.flush && !s;
    a_ix  = produces(hist[0], int'(bus.id_rs));
    a_mem = produces(hist[1], int'(bus.id_rs));
    b_ix  = produces(hist[0], int'(bus.id_rt));
    b_mem = produces(hist[1], int'(bus.id_rt));
    o[5] = s;
    o[4] = go && bus.id_uses_rs && a_ix && !hist[0].load;
    o[3] = go && bus.id_uses_rt && b_ix && !hist[0].load;
    o[2] = go && bus.id_uses_rs && !a_ix && a_mem;
    o[1] = go && bus.id_uses_rt && !b_ix && b_mem;
    o[0] = go && bus.id_is_store && bus.id_uses_rt && b_ix && hist[0].load;
    return o;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hist[0]  = '{0, 0, 0};
      hist[1]  = '{0, 0, 0};
      m_cnt    = 0;
      model_ok = 1;
    end else if (model_ok) begin
      if (m_stall() && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      hist[1] = hist[0];
      if (bus.id_valid && !bus.flush && !m_stall())
        hist[0] = '{bit'(bus.id_write_to_reg), int'(bus.id_dest), bit'(bus.id_is_load)};
      else
        hist[0] = '{0, 0, 0};
    end
  end

  always @(posedge clk) begin
    if (model_ok) begin
      chk("outputs", {26'd0, bus.stall, bus.mx_op1_bypass, bus.mx_op2_bypass,
                      bus.wx_op1_bypass, bus.wx_op2_bypass, bus.wm_data_bypass},
          {26'd0, m_outs()});
      chk("stall_count", 32'(stall_count), 32'(m_cnt));
    end
  end

  task automatic drive(input int v, input int rs, input int rt, input int urs, input int urt,
                       input int st, input int ld, input int wr, input int dest, input int fl);
    bus.id_valid        = v[0];
    bus.id_rs           = RW'(rs);
    bus.id_rt           = RW'(rt);
    bus.id_uses_rs      = urs[0];
    bus.id_uses_rt      = urt[0];
    bus.id_is_store     = st[0];
    bus.id_is_load      = ld[0];
    bus.id_write_to_reg = wr[0];
    bus.id_dest         = RW'(dest);
    bus.flush           = fl[0];
  endtask

  // Present one decode-stage instruction for one cycle; returns #1 after the posedge.
  task automatic apply(input int v, input int rs, input int rt, input int urs, input int urt,
                       input int st, input int ld, input int wr, input int dest, input int fl);
    @(negedge clk); #1;
    rst = 1'b0;
    drive(v, rs, rt, urs, urt, st, ld, wr, dest, fl);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lit(input string name, input logic [5:0] exp);
    chk(name, {26'd0, bus.stall, bus.mx_op1_bypass, bus.mx_op2_bypass,
               bus.wx_op1_bypass, bus.wx_op2_bypass, bus.wm_data_bypass}, {26'd0, exp});
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset then a consumer of $3 with nothing in flight.
    apply(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    lit("reset_outs", 6'b000000);
    chk("reset_cnt", 32'(stall_count), 32'd0);

    // ALU chain: add $5 ; use $5 as rs (MX) ; use $5 as rt (WX)
    apply(1, 1, 2, 1, 1, 0, 0, 1, 5, 0);
    apply(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    lit("alu_mx_op1", 6'b010000);
    apply(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    lit("alu_wx_op2", 6'b000010);

    // Load-use: lw $8 ; use $8 -> one stall, then WX on reissue
    apply(1, 1, 0, 1, 0, 0, 1, 1, 8, 0);
    apply(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    lit("lu_stall", 6'b100000);
    apply(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    lit("lu_reissue", 6'b000100);
    chk("lu_cnt", 32'(stall_count), 32'd1);

    // Load-store: store data from load -> WM; store base from load -> stall
    apply(1, 1, 0, 1, 0, 0, 1, 1, 9, 0);
    apply(1, 1, 9, 1, 1, 1, 0, 0, 0, 0);
    lit("ls_wm", 6'b000001);
    apply(1, 1, 0, 1, 0, 0, 1, 1, 9, 0);
    apply(1, 9, 2, 1, 1, 1, 0, 0, 0, 0);
    lit("ls_base_stall", 6'b100000);
    apply(1, 9, 2, 1, 1, 1, 0, 0, 0, 0);
    lit("ls_base_reissue", 6'b000100);

    // Flush beats stall; squashed instruction leaves a bubble
    apply(1, 1, 0, 1, 0, 0, 1, 1, 4, 0);
    apply(1, 4, 0, 1, 0, 0, 0, 1, 6, 1);
    lit("flush_outs", 6'b000000);
    apply(1, 4, 6, 1, 1, 0, 0, 0, 0, 0);
    lit("flush_after", 6'b000100);
    chk("flush_cnt", 32'(stall_count), 32'd2);

    // $0 destination never forwards
    apply(1, 1, 2, 1, 1, 0, 0, 1, 0, 0);
    apply(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    lit("r0_outs", 6'b000000);

    // Mid-stream reset wipes the scoreboard and counter
    apply(1, 1, 0, 1, 0, 0, 1, 1, 7, 0);
    do_reset();
    apply(1, 7, 7, 1, 1, 0, 0, 0, 0, 0);
    lit("rst_mid_outs", 6'b000000);
    chk("rst_mid_cnt", 32'(stall_count), 32'd0);

    // Saturation: 20 load-use stalls on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      apply(1, 1, 0, 1, 0, 0, 1, 1, 10, 0);
      apply(1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt", 32'(stall_count), 32'd15);

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_bypass_unit.md
Name: hazard_bypass_unit

Overview:
- Decode-stage hazard and forwarding controller, directly upstream of the ID/IX pipeline register.
- Keeps a shadow scoreboard of the destination registers held in IX, MEM and WB.
- Compares the decoding instruction's sources against that scoreboard. From the result it drives the ID/IX stall input and the five bypass selects (mx_op1/op2, wx_op1/op2, wm_data) latched alongside the instruction.
- Also counts load-use stall cycles for performance debug.

Parameters:
- REG_ADDR_WIDTH, 5, register specifier width.
- CNT_WIDTH, 32, stall counter width.

Ports:
- clk  in  1  system clock; all state updates on negedge clk, same edge as the pipeline registers.
- rst  in  1  synchronous, active-high reset, sampled on negedge clk.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  REG_ADDR_WIDTH  source 1 specifier.
- id_rt  in  REG_ADDR_WIDTH  source 2 specifier.
- id_uses_rs  in  1  instruction reads rs as ALU operand 1.
- id_uses_rt  in  1  instruction reads rt (operand 2, or store data).
- id_is_store  in  1  rt is store data only, not an ALU operand.
- id_is_load  in  1  instruction is a load.
- id_write_to_reg  in  1  instruction writes a register.
- id_dest  in  REG_ADDR_WIDTH  resolved destination (rd, rt or 31 for jal).
- flush  in  1  branch/jump taken; squash the decoding instruction.
- stall  out  1  combinational; to ID/IX stall_in and fetch/decode hold.
- mx_op1_bypass, mx_op2_bypass, wx_op1_bypass, wx_op2_bypass, wm_data_bypass  out  1 each  combinational; to ID/IX.
- stall_count  out  CNT_WIDTH  registered count of stall cycles.

Behaviour:
- Scoreboard: three entries, IX/MEM/WB. Each entry is {v, dest, ld}.
- On rst: all v=0, dest=0, ld=0, stall_count=0. Combinational outputs are then 0 for any input.
- Every negedge (no rst):
  - WB<=MEM, MEM<=IX.
  - IX<=bubble (v=0) if stall, flush or !id_valid.
  - Otherwise IX<={id_write_to_reg && id_dest!=0, id_dest, id_is_load}.
- Match definitions:
  - mIX(r) = IX.v && IX.dest==r && r!=0.
  - mMEM(r) is the same test against MEM.
  - WB matches are ignored; the register file writes before it reads.
- Load-use stall:
  - stall = id_valid && !flush && IX.ld && ( (id_uses_rs && mIX(rs)) || (id_uses_rt && !id_is_store && mIX(rt)) ).
  - flush overrides stall: stall=0 whenever flush=1.
- Bypasses (all forced 0 when stall, flush or !id_valid):
  - mx_op1 = id_uses_rs && mIX(rs) && !IX.ld.
  - wx_op1 = id_uses_rs && mMEM(rs) && !mIX(rs).
  - mx_op2 = id_uses_rt && mIX(rt) && !IX.ld.
  - wx_op2 = id_uses_rt && mMEM(rt) && !mIX(rt).
  - wm_data = id_is_store && id_uses_rt && mIX(rt) && IX.ld. A store whose data depends on a load in IX does not stall; the data is forwarded WB->MEM.
  - MX has priority over WX: the newer producer wins. At most one of mx/wx per operand.
- Stall cycle: the stalled instruction is re-presented next cycle. The bubble is now in IX and the load is in MEM, so the reissue gets wx bypass, not stall. Max one stall per load-use.
- stall_count increments on each negedge with stall=1. It saturates at all-ones (no wrap). Reset clears it.
- rst asserted mid-stream: scoreboard cleared on that edge; the next cycle sees no hazards.
- Register 0 never creates a hazard or bypass.

Test Plan:
- Reset: rst=1 one negedge, then id_valid=1, rs=3 uses_rs -> all bypasses 0, stall 0, stall_count 0.
- ALU chain: add $5 issued; next cycle rs=5 -> mx_op1=1. The cycle after, with rt=5 -> wx_op2=1, mx_op2=0.
- Load-use: lw $8; next instr rs=8 -> stall=1 for exactly one cycle, stall_count=1. Reissue -> wx_op1=1, stall=0.
- Load-store data: lw $9; next sw with rt=9 (is_store) -> stall=0, wm_data_bypass=1. Same sw with base rs=9 -> stall=1.
- Flush priority: lw $4, then rs=4 with flush=1 -> stall=0, bypasses 0, IX gets bubble, stall_count unchanged. $0 dest: add $0 then rs=0 -> no bypass.
- Saturation: CNT_WIDTH=4, force 20 stall cycles -> stall_count=15.
